multi_counter_adder: RTL and testbench
======================================

MULTI_COUNTER_ADDER -- requirements
Module: multi_counter_adder

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each counter and of the sum.
REQ-002 Parameter CHANNELS, default 2: number of independent counters summed, legal range 1..16.
REQ-003 Parameter SATURATE, default 0: sum overflow mode; 0 = wrap (truncate), 1 = clamp to 2^WIDTH-1.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_en  input  CHANNELS  per-channel count enable; bit c enables counter c.
REQ-007 i_clr  input  1  synchronous clear of all counters and the sum register.
REQ-008 o_state  output  CHANNELS*WIDTH  counter values; counter c occupies bits [c*WIDTH +: WIDTH].
REQ-009 o_wrap  output  CHANNELS  per-channel one-cycle pulse, high when counter c has just wrapped to 0.
REQ-010 o_sum  output  WIDTH  registered sum of all counters.
REQ-011 o_sum_ovf  output  1  high while o_sum holds a result whose true sum exceeded 2^WIDTH-1.

Function
REQ-012 Each counter SHALL be a registered WIDTH-bit up-counter; at each edge with i_en[c]=1 and i_clr=0 it SHALL take value+1 mod 2^WIDTH; otherwise it SHALL hold.
REQ-013 o_wrap[c] SHALL be registered and SHALL be 1 for exactly the cycle after an edge where counter c went from 2^WIDTH-1 to 0; otherwise 0.
REQ-014 At each edge the sum SHALL be computed at full width WIDTH+ceil(log2(CHANNELS)) from the current registered counter values (pre-edge o_state), so o_sum lags o_state by exactly one cycle.
REQ-015 With SATURATE=0, o_sum SHALL be the full-width sum truncated to WIDTH bits; with SATURATE=1, o_sum SHALL be min(full sum, 2^WIDTH-1).
REQ-016 o_sum_ovf SHALL be registered alongside o_sum, 1 iff the full-width sum > 2^WIDTH-1, in both modes.
REQ-017 With i_clr=1 at an edge, all counters, o_sum, o_sum_ovf and o_wrap SHALL become 0 at that edge, regardless of i_en; i_clr has priority over i_en.
REQ-018 The cycle after a clear, o_sum SHALL be 0 (the sum of the cleared counters), with no stale value appearing.
REQ-019 Channels SHALL be fully independent; enabling, wrapping or holding one channel SHALL NOT affect any other counter.
REQ-020 With CHANNELS=1, the sum SHALL equal the counter delayed by one cycle, and o_sum_ovf SHALL be constant 0.
REQ-021 The design SHALL contain no combinational path from any input to any output; all outputs SHALL be flop outputs.

Reset
REQ-022 While i_rst=1, o_state, o_wrap, o_sum and o_sum_ovf SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 After i_rst deasserts, the first rising edge SHALL behave as a normal edge from the all-zero state.
REQ-024 Asserting i_rst mid-count SHALL discard all in-progress state; no partial sum SHALL survive.

Verification
REQ-025 Default parameters, i_en=2'b11 from reset -> after edge n: each counter = n mod 256, o_sum = 2(n-1) mod 256; at edge 129, o_sum=0 and o_sum_ovf=1.
REQ-026 Same stimulus with SATURATE=1 -> at edge 129, o_sum=255 and o_sum_ovf=1; at edge 130, o_sum=255 (2*129=258 clamped).
REQ-027 Counter 0 at 255 with i_en[0]=1 -> next edge: counter 0 = 0, o_wrap=2'b01 for one cycle, counter 1 unchanged.
REQ-028 i_clr=1 and i_en=2'b11 with counters at 17 and 40 -> next edge: all outputs 0; following edge with i_clr=0: counters 1, o_sum=0.
REQ-029 i_rst pulsed for 1 ns between edges with counters at 100 and 5 -> all outputs 0 before the next edge; counting restarts from 0.
REQ-030 CHANNELS=4, WIDTH=4, only i_en[2]=1 for 20 edges -> counter 2 = 4, others 0, o_wrap[2] pulsed once (after edge 16), o_sum = 3.

Source files
------------

// File: rtl/multi_counter_adder_if.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : multi_counter_adder_if
//  Description : Bundle of the control inputs and observable outputs of the
//                multi_counter_adder block.
//                  i_en      [CHANNELS]        per-channel count enable
//                  i_clr                       synchronous clear of all state
//                  o_state   [CHANNELS*WIDTH]  counter c at [c*WIDTH +: WIDTH]
//                  o_wrap    [CHANNELS]        one-cycle wrap pulse per channel
//                  o_sum     [WIDTH]           registered sum of the counters
//                  o_sum_ovf                   true sum exceeded 2^WIDTH-1
//                master : the controlling side (drives i_en / i_clr)
//                slave  : the counter block (drives all o_* signals)
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_counter_adder_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       i_en;
    logic                      i_clr;
    logic [CHANNELS*WIDTH-1:0] o_state;
    logic [CHANNELS-1:0]       o_wrap;
    logic [WIDTH-1:0]          o_sum;
    logic                      o_sum_ovf;

    modport master (
        output i_en,
        output i_clr,
        input  o_state,
        input  o_wrap,
        input  o_sum,
        input  o_sum_ovf
    );

    modport slave (
        input  i_en,
        input  i_clr,
        output o_state,
        output o_wrap,
        output o_sum,
        output o_sum_ovf
    );
endinterface
`default_nettype wire

// File: rtl/multi_counter_adder.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : multi_counter_adder
//  Description : CHANNELS independent WIDTH-bit up-counters plus a registered
//                sum of all counters. The sum is built from the counter values
//                present before each edge, so o_sum trails o_state by exactly
//                one cycle. Sum overflow either wraps (SATURATE=0) or clamps
//                to 2^WIDTH-1 (SATURATE=1); o_sum_ovf flags overflow in both
//                modes.
//  Ports       : i_clk  clock, rising edge
//                i_rst  asynchronous, active-high reset
//                bus    multi_counter_adder_if.slave
//                       (i_en, i_clr in; o_state, o_wrap, o_sum, o_sum_ovf out)
//  Revision    : 1.0  initial release
// ============================================================================
module multi_counter_adder #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,      // legal range 1..16
    parameter bit SATURATE = 1'b0    // 0: wrap sum, 1: clamp sum
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    multi_counter_adder_if.slave    bus
);

    // Full-precision sum width: enough headroom for CHANNELS maximal counters.
    localparam int               c_sum_w = WIDTH + $clog2(CHANNELS);
    localparam logic [WIDTH-1:0] c_max   = {WIDTH{1'b1}};

    logic [CHANNELS*WIDTH-1:0] w_state;
    logic [CHANNELS-1:0]       w_wrap;
    logic [c_sum_w-1:0]        w_full_sum;
    logic                      w_sum_ovf;
    logic [WIDTH-1:0]          w_sum_next;
    logic [WIDTH-1:0]          r_sum;
    logic                      r_sum_ovf;

    // ------------------------------------------------------------------------
    // Per-channel counters. Each channel owns its own registers so that no
    // channel's enable can ever touch another channel's state.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] r_cnt;
        logic             r_wrap;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt  <= '0;
                r_wrap <= 1'b0;
            end else if (bus.i_clr) begin
                // Clear wins over enable.
                r_cnt  <= '0;
                r_wrap <= 1'b0;
            end else if (bus.i_en[c]) begin
                r_cnt  <= r_cnt + 1'b1;
                // Pulse on the edge that rolls all-ones over to zero.
                r_wrap <= (r_cnt == c_max);
            end else begin
                r_wrap <= 1'b0;
            end
        end

        assign w_state[c*WIDTH +: WIDTH] = r_cnt;
        assign w_wrap[c]                 = r_wrap;
    end

    // ------------------------------------------------------------------------
    // Full-width sum of the current (pre-edge) counter values.
    // ------------------------------------------------------------------------
    always_comb begin
        w_full_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_full_sum = w_full_sum + c_sum_w'(w_state[c*WIDTH +: WIDTH]);
        end
    end

    // Overflow means any bit above the WIDTH-bit result is set. With a single
    // channel there are no such bits and the flag can never rise.
    if (c_sum_w > WIDTH) begin : g_ovf
        assign w_sum_ovf = |w_full_sum[c_sum_w-1:WIDTH];
    end else begin : g_no_ovf
        assign w_sum_ovf = 1'b0;
    end

    if (SATURATE) begin : g_sat
        assign w_sum_next = w_sum_ovf ? c_max : w_full_sum[WIDTH-1:0];
    end else begin : g_trunc
        assign w_sum_next = w_full_sum[WIDTH-1:0];
    end

    // ------------------------------------------------------------------------
    // Sum register. A clear zeroes the sum at the same edge as the counters;
    // the edge after a clear then sums the zeroed counters, so no stale value
    // can appear.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum     <= '0;
            r_sum_ovf <= 1'b0;
        end else if (bus.i_clr) begin
            r_sum     <= '0;
            r_sum_ovf <= 1'b0;
        end else begin
            r_sum     <= w_sum_next;
            r_sum_ovf <= w_sum_ovf;
        end
    end

    // All outputs come straight from flops.
    assign bus.o_state   = w_state;
    assign bus.o_wrap    = w_wrap;
    assign bus.o_sum     = r_sum;
    assign bus.o_sum_ovf = r_sum_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multi_counter_adder.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : tb_multi_counter_adder
//  Description : Self-checking bench for multi_counter_adder. Two instances:
//                dut0 WIDTH=8 CHANNELS=2 wrapping sum, dut1 WIDTH=4
//                CHANNELS=4 clamping sum. A behavioural model of counters and
//                sum is stepped at each edge and compared every cycle, with
//                literal expectations pinning known points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_counter_adder;

    typedef struct packed {
        logic [15:0][7:0] cnt;
        logic [15:0]      wrap;
        logic [7:0]       sum;
        logic             ovf;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_counter_adder_if #(.WIDTH(8), .CHANNELS(2)) bus0 ();
    multi_counter_adder_if #(.WIDTH(4), .CHANNELS(4)) bus1 ();

    multi_counter_adder #(.WIDTH(8), .CHANNELS(2), .SATURATE(1'b0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    multi_counter_adder #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   wrap_pulses = 0;
    mdl_t m0, m1;

    // Model step: counters increment mod 2^w when enabled, the sum is the
    // arithmetic total of the counters as they stood before the edge.
    function automatic mdl_t mstep(mdl_t m, int w, int ch, bit sat,
                                   logic [15:0] en, bit clr);
        mdl_t n;
        int   full = 0;
        int   maxv = (1 << w) - 1;
        n = '0;
        for (int c = 0; c < ch; c++) full += int'(m.cnt[c]);
        if (!clr) begin
            for (int c = 0; c < ch; c++) begin
                if (en[c]) begin
                    n.cnt[c]  = 8'((int'(m.cnt[c]) + 1) % (maxv + 1));
                    n.wrap[c] = (int'(m.cnt[c]) == maxv);
                end else begin
                    n.cnt[c] = m.cnt[c];
                end
            end
            n.ovf = (full > maxv);
            n.sum = sat ? 8'((full > maxv) ? maxv : full) : 8'(full % (maxv + 1));
        end
        return n;
    endfunction

    function automatic logic [15:0] pack(mdl_t m, int w, int ch);
        logic [15:0] s = '0;
        for (int c = 0; c < ch; c++)
            for (int b = 0; b < w; b++)
                s[c*w+b] = m.cnt[c][b];
        return s;
    endfunction

    task automatic lit(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(string name, logic [15:0] st, logic [15:0] wr,
                       logic [7:0] sm, logic ov, mdl_t m, int w, int ch);
        logic [15:0] est;
        logic [15:0] ewr;
        est = pack(m, w, ch);
        ewr = m.wrap & 16'((1 << ch) - 1);
        vectors++;
        if (st !== est || wr !== ewr || sm !== m.sum || ov !== m.ovf) begin
            miscompares++;
            $display("FAIL %s @%0t: state %h/%h wrap %h/%h sum %h/%h ovf %b/%b (got/expected)",
                     name, $time, st, est, wr, ewr, sm, m.sum, ov, m.ovf);
        end
    endtask

    task automatic check_all();
        cmp("dut0", 16'(bus0.o_state), 16'(bus0.o_wrap), 8'(bus0.o_sum),
            bus0.o_sum_ovf, m0, 8, 2);
        cmp("dut1", 16'(bus1.o_state), 16'(bus1.o_wrap), 8'(bus1.o_sum),
            bus1.o_sum_ovf, m1, 4, 4);
    endtask

    // Drive inputs, step the model at the edge, compare on the falling edge.
    task automatic tick(logic [1:0] e0, logic [3:0] e1, bit clr);
        bus0.i_en  = e0;
        bus0.i_clr = clr;
        bus1.i_en  = e1;
        bus1.i_clr = clr;
        @(posedge clk);
        m0 = mstep(m0, 8, 2, 1'b0, 16'(e0), clr);
        m1 = mstep(m1, 4, 4, 1'b1, 16'(e1), clr);
        @(negedge clk);
        check_all();
        if (bus1.o_wrap[2] === 1'b1) wrap_pulses++;
    endtask

    task automatic lit_zero(string name);
        lit({name, "_state0"}, int'(bus0.o_state), 0);
        lit({name, "_wrap0"},  int'(bus0.o_wrap),  0);
        lit({name, "_sum0"},   int'(bus0.o_sum),   0);
        lit({name, "_ovf0"},   int'(bus0.o_sum_ovf), 0);
        lit({name, "_state1"}, int'(bus1.o_state), 0);
        lit({name, "_sum1"},   int'(bus1.o_sum),   0);
    endtask

    // Short reset pulse between edges; outputs must drop without a clock.
    task automatic rst_pulse(string name);
        #2;
        rst = 1'b1;
        #0.5;
        lit_zero(name);
        #0.5;
        rst = 1'b0;
        m0 = '0;
        m1 = '0;
    endtask

    initial begin
        rst        = 1'b1;
        bus0.i_en  = '0;
        bus0.i_clr = 1'b0;
        bus1.i_en  = '0;
        bus1.i_clr = 1'b0;
        m0 = '0;
        m1 = '0;

        #3;
        lit_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Both dut0 counters from reset; dut1 only channel 2.
        wrap_pulses = 0;
        for (int n = 1; n <= 130; n++) begin
            tick(2'b11, 4'b0100, 1'b0);
            if (n == 20) begin
                lit("ch4_cnt2", int'(bus1.o_state[11:8]), 4);
                lit("ch4_others", int'({bus1.o_state[15:12], bus1.o_state[7:0]}), 0);
                lit("ch4_sum", int'(bus1.o_sum), 3);
                lit("ch4_wrap_pulses", wrap_pulses, 1);
            end
            if (n == 129) begin
                lit("e129_state", int'(bus0.o_state), 16'h8181);
                lit("e129_sum", int'(bus0.o_sum), 0);
                lit("e129_ovf", int'(bus0.o_sum_ovf), 1);
            end
            if (n == 130) begin
                lit("e130_sum", int'(bus0.o_sum), 2);
                lit("e130_ovf", int'(bus0.o_sum_ovf), 1);
            end
        end

        // Advance only counter 0 up to 255, then let it wrap.
        for (int k = 0; k < 125; k++) tick(2'b01, 4'($urandom), 1'b0);
        lit("pre_wrap_cnt0", int'(bus0.o_state[7:0]), 255);
        tick(2'b01, 4'b0000, 1'b0);
        lit("wrap_cnt0", int'(bus0.o_state[7:0]), 0);
        lit("wrap_cnt1", int'(bus0.o_state[15:8]), 130);
        lit("wrap_pulse", int'(bus0.o_wrap), 1);
        tick(2'b00, 4'b0000, 1'b0);
        lit("wrap_gone", int'(bus0.o_wrap), 0);

        // Clear with all enables set; clear wins.
        tick(2'b11, 4'b1111, 1'b1);
        lit_zero("clear");
        for (int k = 1; k <= 8; k++) begin
            tick(2'b11, 4'b1111, 1'b0);
            if (k == 1) begin
                lit("post_clr_state", int'(bus0.o_state), 16'h0101);
                lit("post_clr_sum", int'(bus0.o_sum), 0);
            end
            if (k == 8) begin
                lit("clamp_state", int'(bus1.o_state), 16'h8888);
                lit("clamp_sum", int'(bus1.o_sum), 15);
                lit("clamp_ovf", int'(bus1.o_sum_ovf), 1);
            end
        end

        // Async reset mid-count, then counting resumes from zero.
        rst_pulse("arst");
        tick(2'b11, 4'b0001, 1'b0);
        lit("arst_restart", int'(bus0.o_state), 16'h0101);
        lit("arst_sum", int'(bus0.o_sum), 0);

        // Randomised traffic with rare clears and reset pulses.
        for (int k = 0; k < 700; k++) begin
            tick(2'($urandom), 4'($urandom), ($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 299) == 0) rst_pulse("rand_arst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
